// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port, memory port and stall signals of mem_arbiter.
// The arbiter uses the slave modport; the pipeline/memory side uses master.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          stall_if;
  logic          stall_mem;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    output i_rdata, i_ready, d_rdata, d_ready,
           mem_read, mem_write, mem_addr, mem_wd, stall_if, stall_mem
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    input  i_rdata, i_ready, d_rdata, d_ready,
           mem_read, mem_write, mem_addr, mem_wd, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one unified memory between instruction fetch and load/store.
// Data wins by default; a starvation counter forces a fetch after MAX_STARVE data grants.
module mem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned MAX_STARVE = 4
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned SW = $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] starve_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic          gnt_d_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          i_ready_q;
  logic          d_ready_q;
  logic          mem_read_q;
  logic          mem_write_q;

  logic pick_d;
  logic pick_i;
  logic last_c;
  logic next_last_c;

  assign pick_d      = bus.d_req && ((starve_q < SW'(MAX_STARVE)) || !bus.i_req);
  assign pick_i      = !pick_d && bus.i_req;
  assign last_c      = (cnt_q == CW'(LATENCY - 1));
  assign next_last_c = ((cnt_q + CW'(1)) == CW'(LATENCY - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      gnt_d_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_d || pick_i) begin
            state_q     <= BUSY;
            cnt_q       <= '0;
            gnt_d_q     <= pick_d;
            addr_q      <= pick_d ? bus.d_addr : bus.i_addr;
            we_q        <= pick_d && bus.d_we;
            mem_read_q  <= !(pick_d && bus.d_we);
            mem_write_q <= pick_d && bus.d_we && (LATENCY == 1);
            if (pick_d) wdata_q <= bus.d_wdata;
            // Only data grants that bypass a waiting fetch count towards starvation.
            if (pick_i || !bus.i_req)
              starve_q <= '0;
            else if (starve_q < SW'(MAX_STARVE))
              starve_q <= starve_q + SW'(1);
          end
        end
        BUSY: begin
          if (last_c) begin
            state_q     <= DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_ready_q   <= !gnt_d_q;
            d_ready_q   <= gnt_d_q;
            if (!we_q) begin
              if (gnt_d_q) d_rdata_q <= bus.mem_rd;
              else         i_rdata_q <= bus.mem_rd;
            end
          end else begin
            cnt_q       <= cnt_q + CW'(1);
            mem_write_q <= we_q && next_last_c;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_ready   = i_ready_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wd    = wdata_q;
  assign bus.stall_if  = bus.i_req && !i_ready_q;
  assign bus.stall_mem = bus.d_req && !d_ready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word-addressed memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   wr_cnt = 0;

  logic [31:0] mem [0:1023];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_a  = '0;
  logic [31:0] ld_d  = '0;

  mem_arbiter_if #(.AW(32), .DW(32)) bus();

  mem_arbiter #(.AW(32), .DW(32), .LATENCY(2), .MAX_STARVE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rd = mem[bus.mem_addr[11:2]];

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[11:2]] <= bus.mem_wd;
    else if (ld_en)    mem[ld_a] <= ld_d;
  end

  always @(posedge clk) if (bus.mem_write) wr_cnt <= wr_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1;
    ld_a  = a[11:2];
    ld_d  = d;
    nxt();
    ld_en = 1'b0;
  endtask

  initial begin
    int first, second, d_cyc, i_cyc, n, wr0, ic;
    logic exp_d [10];
    logic got_d [10];

    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;

    preload(32'h40,  32'h8C010004);
    preload(32'h44,  32'h00000013);
    preload(32'h10,  32'h11110010);
    preload(32'h14,  32'h22220014);
    preload(32'h100, 32'h00000000);
    preload(32'h200, 32'h00000055);

    // Reset values
    smp();
    chk("rst_i_ready",   32'(bus.i_ready),   32'd0);
    chk("rst_d_ready",   32'(bus.d_ready),   32'd0);
    chk("rst_mem_read",  32'(bus.mem_read),  32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_addr",  bus.mem_addr,       32'd0);
    chk("rst_mem_wd",    bus.mem_wd,         32'd0);
    chk("rst_i_rdata",   bus.i_rdata,        32'd0);
    chk("rst_d_rdata",   bus.d_rdata,        32'd0);
    nxt();
    rst = 1'b1;
    nxt();

    // Fetch from 0x40
    bus.i_req = 1; bus.i_addr = 32'h40;
    smp();
    chk("f_c0_stall_if", 32'(bus.stall_if), 32'd1);
    chk("f_c0_mem_read", 32'(bus.mem_read), 32'd0);
    nxt(); smp();
    chk("f_c1_mem_read", 32'(bus.mem_read), 32'd1);
    chk("f_c1_mem_addr", bus.mem_addr,      32'h40);
    chk("f_c1_stall_if", 32'(bus.stall_if), 32'd1);
    nxt(); smp();
    chk("f_c2_mem_read", 32'(bus.mem_read), 32'd1);
    chk("f_c2_mem_addr", bus.mem_addr,      32'h40);
    chk("f_c2_i_ready",  32'(bus.i_ready),  32'd0);
    nxt(); smp();
    chk("f_c3_i_ready",  32'(bus.i_ready),  32'd1);
    chk("f_c3_i_rdata",  bus.i_rdata,       32'h8C010004);
    chk("f_c3_stall_if", 32'(bus.stall_if), 32'd0);
    chk("f_c3_mem_read", 32'(bus.mem_read), 32'd0);
    nxt();
    bus.i_req = 0;
    smp();
    chk("f_c4_i_ready",  32'(bus.i_ready),  32'd0);

    // Back-to-back loads 0x10 then 0x14
    nxt();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h10;
    first = -1; second = -1;
    for (int c = 0; c < 12; c++) begin
      smp();
      if (bus.d_ready) begin
        if (first < 0) begin
          first = c;
          chk("ld0_d_rdata", bus.d_rdata, 32'h11110010);
        end else begin
          second = c;
          chk("ld1_d_rdata", bus.d_rdata, 32'h22220014);
        end
      end
      nxt();
      if (c == 3) bus.d_addr = 32'h14;
      if (second >= 0) bus.d_req = 0;
    end
    chk("ld0_ready_cycle", 32'(first),  32'd3);
    chk("ld1_ready_cycle", 32'(second), 32'd7);

    // Store 0xDEADBEEF to 0x100
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF;
    smp();
    chk("st_c0_mem_write", 32'(bus.mem_write), 32'd0);
    nxt(); smp();
    chk("st_c1_mem_write", 32'(bus.mem_write), 32'd0);
    chk("st_c1_mem_read",  32'(bus.mem_read),  32'd0);
    nxt(); smp();
    chk("st_c2_mem_write", 32'(bus.mem_write), 32'd1);
    chk("st_c2_mem_wd",    bus.mem_wd,         32'hDEADBEEF);
    chk("st_c2_mem_addr",  bus.mem_addr,       32'h100);
    nxt(); smp();
    chk("st_c3_d_ready",   32'(bus.d_ready),   32'd1);
    chk("st_c3_mem_write", 32'(bus.mem_write), 32'd0);
    chk("st_c3_d_rdata",   bus.d_rdata,        32'h22220014);
    nxt();
    bus.d_req = 0; bus.d_we = 0;
    smp();
    chk("st_memory",  mem[32'h100 >> 2], 32'hDEADBEEF);
    chk("st_wr_cnt",  32'(wr_cnt),       32'd1);

    // Simultaneous fetch 0x44 and load 0x100
    nxt();
    bus.i_req = 1; bus.i_addr = 32'h44;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
    d_cyc = -1; i_cyc = -1;
    for (int c = 0; c < 12; c++) begin
      smp();
      if (bus.d_ready) begin
        d_cyc = c;
        chk("sim_d_rdata", bus.d_rdata, 32'hDEADBEEF);
      end
      if (bus.i_ready) begin
        i_cyc = c;
        chk("sim_i_rdata", bus.i_rdata, 32'h00000013);
      end
      if (c == 5) chk("sim_c5_mem_addr", bus.mem_addr, 32'h44);
      nxt();
      if (d_cyc >= 0) bus.d_req = 0;
      if (i_cyc >= 0) bus.i_req = 0;
    end
    chk("sim_d_ready_cycle", 32'(d_cyc), 32'd3);
    chk("sim_i_ready_cycle", 32'(i_cyc), 32'd7);

    // Starvation: both requests held, expect D,D,D,D,I repeating
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus.i_req = 1; bus.i_addr = 32'h40;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h10;
    n = 0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      smp();
      if (bus.d_ready && n < 10) begin got_d[n] = 1'b1; n++; end
      if (bus.i_ready && n < 10) begin got_d[n] = 1'b0; n++; end
      nxt();
    end
    bus.i_req = 0; bus.d_req = 0;
    chk("starve_grants", 32'(n), 32'd10);
    for (int k = 0; k < 10; k++)
      if (k < n) chk($sformatf("starve_order_%0d", k), 32'(got_d[k]), 32'(exp_d[k]));

    // Reset in the first BUSY cycle of a store to 0x200
    nxt();
    wr0 = wr_cnt;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h11;
    nxt();
    rst = 1'b0;
    bus.d_req = 0; bus.d_we = 0;
    smp();
    chk("rm_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rm_mem_read",  32'(bus.mem_read),  32'd0);
    chk("rm_mem_addr",  bus.mem_addr,       32'd0);
    chk("rm_mem_wd",    bus.mem_wd,         32'd0);
    chk("rm_i_rdata",   bus.i_rdata,        32'd0);
    chk("rm_d_rdata",   bus.d_rdata,        32'd0);
    chk("rm_d_ready",   32'(bus.d_ready),   32'd0);
    nxt(); nxt();
    rst = 1'b1;
    smp();
    chk("rm_memory", mem[32'h200 >> 2], 32'h00000055);
    chk("rm_wr_cnt", 32'(wr_cnt),       32'(wr0));
    chk("rm_d_ready_after", 32'(bus.d_ready), 32'd0);

    // Fresh fetch after reset proves the FSM restarted in IDLE
    nxt();
    bus.i_req = 1; bus.i_addr = 32'h40;
    ic = -1;
    for (int c = 0; c < 10; c++) begin
      smp();
      if (bus.i_ready) begin
        ic = c;
        chk("pr_i_rdata", bus.i_rdata, 32'h8C010004);
      end
      nxt();
      if (ic >= 0) bus.i_req = 0;
    end
    chk("pr_ready_cycle", 32'(ic), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
